// File: rtl/sram_frame_reader.sv
// sram_frame_reader: plays a half-resolution 8-bit image stored in an
// asynchronous SRAM out to a VGA port. Each stored byte is shown as a 2x2
// block of screen pixels. Pixel timing comes from a free-running clock
// divider; every other piece of state advances only on pixel ticks.
module sram_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    output logic [17:0] addr,
    inout  wire  [7:0]  io,
    output logic        cs,
    output logic        oe,
    output logic        we,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out,
    output logic        busy,
    output logic [1:0]  frame_count
);

    // ------------------------------------------------------------------
    // Derived timing constants, sized to the counters they are compared to
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so sync-end constants never wrap
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q,  div_d;
    logic [HW-1:0] h_q,    h_d;
    logic [VW-1:0] v_q,    v_d;
    state_t        state_q, state_d;
    logic          cs_q,   cs_d;
    logic          oe_q,   oe_d;
    logic          busy_q, busy_d;
    logic [17:0]   addr_q, addr_d;
    logic [17:0]   line_base_q, line_base_d;
    logic [3:0]    r_q, r_d;
    logic [3:0]    g_q, g_d;
    logic [3:0]    b_q, b_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic [1:0]    frame_count_q, frame_count_d;

    // ------------------------------------------------------------------
    // Decoded pixel position
    // ------------------------------------------------------------------
    logic        tick;
    logic        h_end;
    logic        v_end;
    logic        frame_end;
    logic        pix_active;
    logic        raw_h_sync;
    logic        raw_v_sync;
    logic        in_play;
    logic [17:0] addr_inc;

    // The bus is only ever read; keep it released at all times
    assign io = {8{1'bz}};

    // Colour expansion: each 2-bit field of the byte becomes a 4-bit level.
    // Index 0 = red (d[1:0]), 1 = green (d[3:2]), 2 = blue (d[5:4]).
    logic [3:0] pix_colour [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_colour
            assign pix_colour[gi] = {io[2*gi+1 -: 2], io[2*gi+1 -: 2]};
        end
    endgenerate

    // The top two data bits carry no colour information
    logic io_top_unused;
    assign io_top_unused = ^io[7:6];

    // Position decode shared by the counters, FSM and pixel pipeline
    always_comb begin
        tick       = (div_q == DIV_LAST);
        h_end      = (h_q == H_LAST);
        v_end      = (v_q == V_LAST);
        frame_end  = tick && h_end && v_end;
        pix_active = (h_q < H_ACT_END) && (v_q < V_ACT_END);
        raw_h_sync = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
        raw_v_sync = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
        in_play    = (state_q == ST_PLAY);
        addr_inc   = addr_q + 18'd1;
    end

    // Next values for the pixel divider and the h/v raster counters
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_end) begin
                h_d = '0;
                v_d = v_end ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Raster counters; the divider restarts from zero out of reset
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Playback state decisions; playback always starts and stops on the
    // tick that wraps the raster back to (0,0), so a frame is never cut
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: if (enable) state_d = ST_ARM;
                ST_ARM: begin
                    if (!enable)        state_d = ST_IDLE;
                    else if (frame_end) state_d = ST_PLAY;
                end
                ST_PLAY: if (frame_end && !enable) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        // Strobes follow the state they will accompany
        cs_d   = (state_d != ST_PLAY);
        oe_d   = (state_d != ST_PLAY);
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state with registered SRAM strobes and busy flag
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b1;
            oe_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    // Address walk: two screen pixels per byte horizontally, and each
    // stored row is read twice (even screen line, then odd screen line)
    always_comb begin
        addr_d      = addr_q;
        line_base_d = line_base_q;
        if (tick) begin
            if (frame_end || !in_play) begin
                addr_d      = '0;
                line_base_d = '0;
            end else if (pix_active) begin
                if (h_q == H_ACT_LAST) begin
                    if (!v_q[0]) begin
                        // first pass of this row done: replay it
                        addr_d = line_base_q;
                    end else begin
                        // second pass done: next row starts here
                        addr_d      = addr_inc;
                        line_base_d = addr_inc;
                    end
                end else if (h_q[0]) begin
                    addr_d = addr_inc;
                end
            end
        end
    end

    // SRAM address and the base address of the stored row being shown
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            line_base_q <= '0;
        end else begin
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
        end
    end

    // Pixel pipeline: data for the pixel being left is captured on the tick
    // that ends it, and the syncs are delayed by the same single tick
    always_comb begin
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        frame_count_d = frame_count_q;
        if (tick) begin
            h_sync_d = raw_h_sync;
            v_sync_d = raw_v_sync;
            if (in_play && pix_active) begin
                r_d = pix_colour[0];
                g_d = pix_colour[1];
                b_d = pix_colour[2];
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
            if (in_play && frame_end) begin
                frame_count_d = frame_count_q + 2'd1;
            end
        end
    end

    // Registered colour, delayed syncs and played-frame counter
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            frame_count_q <= '0;
        end else begin
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign addr        = addr_q;
    assign cs          = cs_q;
    assign oe          = oe_q;
    assign we          = 1'b1;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb_sram_frame_reader: small-raster bench for sram_frame_reader with an
// SRAM model returning addr[7:0] ^ mask and a per-tick reference model.
module tb_sram_frame_reader;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int PD  = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_PLAY = 2;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  mask   = 8'h00;
    logic [17:0] addr;
    wire  [7:0]  io;
    logic        cs, oe, we, h_sync, v_sync, busy;
    logic [3:0]  r_out, g_out, b_out;
    logic [1:0]  frame_count;

    // SRAM model: asynchronous read, contents addr[7:0] xor a bench mask
    assign io = addr[7:0] ^ mask;

    sram_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIX_DIV(PD)
    ) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable),
        .addr(addr), .io(io), .cs(cs), .oe(oe), .we(we),
        .h_sync(h_sync), .v_sync(v_sync),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int steps = 0;

    // Reference model: raster position of the pixel now on screen, the
    // playback state, and the outputs registered at the last tick
    int         m_h, m_v, m_st, m_fc;
    logic [3:0] m_r, m_g, m_b;
    logic       m_hs, m_vs;

    typedef struct {
        logic [7:0] data;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } col_vec_t;

    // Address the SRAM should see while pixel (h,v) is on screen
    function automatic logic [17:0] model_addr(int h, int v, int st);
        int row;
        if (st != M_PLAY) return 18'd0;
        if (v >= VA) return 18'((VA / 2) * (HA / 2));
        row = v / 2;
        if (h < HA) return 18'(row * (HA / 2) + h / 2);
        if (v % 2 == 0) return 18'(row * (HA / 2));
        return 18'((row + 1) * (HA / 2));
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_st = M_IDLE; m_fc = 0;
        m_r = 4'h0; m_g = 4'h0; m_b = 4'h0;
        m_hs = 1'b1; m_vs = 1'b1;
    endtask

    // One pixel tick of the reference model, using pre-tick position
    task automatic model_tick(input bit en);
        logic [17:0] a;
        logic [7:0]  d;
        bit fe, act;
        a   = model_addr(m_h, m_v, m_st);
        d   = a[7:0] ^ mask;
        fe  = (m_h == HT - 1) && (m_v == VT - 1);
        act = (m_h < HA) && (m_v < VA);
        if (m_st == M_PLAY && act) begin
            m_r = {d[1:0], d[1:0]};
            m_g = {d[3:2], d[3:2]};
            m_b = {d[5:4], d[5:4]};
        end else begin
            m_r = 4'h0; m_g = 4'h0; m_b = 4'h0;
        end
        m_hs = !((m_h >= HA + HFP) && (m_h < HA + HFP + HS));
        m_vs = !((m_v >= VA + VFP) && (m_v < VA + VFP + VS));
        if (m_st == M_PLAY && fe) m_fc = (m_fc + 1) % 4;
        case (m_st)
            M_IDLE: if (en) m_st = M_ARM;
            M_ARM:  if (!en) m_st = M_IDLE; else if (fe) m_st = M_PLAY;
            default: if (fe && !en) m_st = M_IDLE;
        endcase
        m_h = m_h + 1;
        if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v + 1) % VT;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at step %0d: got 0x%0h, expected 0x%0h", name, steps, act, exp);
        end
    endtask

    task automatic check_all();
        check("addr", 32'(addr), 32'(model_addr(m_h, m_v, m_st)));
        check("cs", 32'(cs), 32'(m_st != M_PLAY));
        check("oe", 32'(oe), 32'(m_st != M_PLAY));
        check("we", 32'(we), 32'd1);
        check("busy", 32'(busy), 32'(m_st != M_IDLE));
        check("h_sync", 32'(h_sync), 32'(m_hs));
        check("v_sync", 32'(v_sync), 32'(m_vs));
        check("r_out", 32'(r_out), 32'(m_r));
        check("g_out", 32'(g_out), 32'(m_g));
        check("b_out", 32'(b_out), 32'(m_b));
        check("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_cs"}, 32'(cs), 32'd1);
        check({tag, "_oe"}, 32'(oe), 32'd1);
        check({tag, "_we"}, 32'(we), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_h_sync"}, 32'(h_sync), 32'd1);
        check({tag, "_v_sync"}, 32'(v_sync), 32'd1);
        check({tag, "_rgb"}, 32'({r_out, g_out, b_out}), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // One pixel: drive enable, let the edge happen, compare on the far edge
    task automatic step(input bit en);
        enable = en;
        @(posedge clk_in);
        model_tick(en);
        @(negedge clk_in);
        steps++;
        check_all();
        $display("[TB] step %0d en=%0b h=%0d v=%0d st=%0d addr=%0d rgb=%h%h%h hs=%b vs=%b fc=%0d",
                 steps, en, m_h, m_v, m_st, addr, r_out, g_out, b_out, h_sync, v_sync, frame_count);
    endtask

    // Asynchronous reset dropped between clock edges, called at a negedge
    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk_in);
        check_reset_outputs("reset_held_edge");
        reset = 1'b1;
        model_reset();
    endtask

    int exp_addr [3][HA] = '{'{0, 0, 1, 1, 2, 2, 3, 3},
                             '{0, 0, 1, 1, 2, 2, 3, 3},
                             '{4, 4, 5, 5, 6, 6, 7, 7}};

    initial begin
        col_vec_t vec [6];
        int  hl, vl;
        bit  en_r;

        vec[0] = '{data: 8'h2D, r: 4'h5, g: 4'hF, b: 4'hA};
        vec[1] = '{data: 8'h00, r: 4'h0, g: 4'h0, b: 4'h0};
        vec[2] = '{data: 8'hFF, r: 4'hF, g: 4'hF, b: 4'hF};
        vec[3] = '{data: 8'h1B, r: 4'hF, g: 4'hA, b: 4'h5};
        vec[4] = '{data: 8'hC4, r: 4'h0, g: 4'h5, b: 4'h0};
        vec[5] = '{data: 8'h36, r: 4'hA, g: 4'h5, b: 4'hF};
        // 0x2D = 0010_1101: r=01->5, g=11->F, b=10->A
        model_reset();

        // Reset held with enable high: nothing may start
        enable = 1'b1;
        repeat (4) @(negedge clk_in);
        check_reset_outputs("reset_held");
        enable = 1'b0;
        reset  = 1'b1;

        // Two idle frames: syncs run, strobes and colour stay quiet
        hl = 0; vl = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'b0);
            if (i < HT) hl += int'(!h_sync);
            if (i < HT * VT) vl += int'(!v_sync);
        end
        check("h_sync_low_ticks", 32'(hl), 32'(HS));
        check("v_sync_low_ticks", 32'(vl), 32'(VS * HT));

        // Enable mid-frame: armed, but SRAM untouched until frame start
        repeat (20) step(1'b0);
        step(1'b1);
        check("armed_busy", 32'(busy), 32'd1);
        check("armed_cs", 32'(cs), 32'd1);
        while (!(m_h == HT - 1 && m_v == VT - 1)) step(1'b1);
        check("armed_cs_before_start", 32'(cs), 32'd1);
        step(1'b1);
        check("play_cs", 32'(cs), 32'd0);

        // Address pattern over the first three lines
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < HT; h++) begin
                if (h < HA) check("line_addr", 32'(addr), 32'(exp_addr[v][h]));
                step(1'b1);
            end
        end
        while (!(m_h == 0 && m_v == 0)) step(1'b1);
        check("frame_end_addr", 32'(addr), 32'd0);
        check("frame_count_one", 32'(frame_count), 32'd1);

        // Colour mapping table: data placed at stored pixel 0 of a frame
        for (int i = 0; i < 6; i++) begin
            while (!(m_h == HT - 1 && m_v == VT - 1)) step(1'b1);
            mask = vec[i].data;
            step(1'b1);
            step(1'b1);
            check("tbl_r", 32'(r_out), 32'(vec[i].r));
            check("tbl_g", 32'(g_out), 32'(vec[i].g));
            check("tbl_b", 32'(b_out), 32'(vec[i].b));
            check("tbl_h_sync", 32'(h_sync), 32'd1);
        end
        mask = 8'h00;

        // Enable dropped during line 2: frame finishes, then idle
        while (!(m_v == 2 && m_h == 3)) step(1'b1);
        while (!(m_h == HT - 1 && m_v == VT - 1)) step(1'b0);
        check("stop_busy_before_end", 32'(busy), 32'd1);
        step(1'b0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_cs", 32'(cs), 32'd1);
        check("stop_oe", 32'(oe), 32'd1);
        repeat (HT) step(1'b0);
        check("stop_rgb", 32'({r_out, g_out, b_out}), 32'd0);

        // Asynchronous reset in the middle of a played line
        for (int i = 0; i < 4 * HT * VT; i++) begin
            if (m_st == M_PLAY && m_v == 1 && m_h == 3) break;
            step(1'b1);
        end
        check("reached_play_line1", 32'(m_st), 32'(M_PLAY));
        async_reset_pulse();
        step(1'b1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_cs", 32'(cs), 32'd1);

        // Randomized run against the reference model
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(149, 0) == 0) en_r = !en_r;
            mask = 8'($urandom);
            if ($urandom_range(599, 0) == 0) async_reset_pulse();
            step(en_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
